// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives one external Montgomery multiplier over a start/done handshake.
module mod_exp_ctrl #(
   parameter int WIDTH   = 512,
   parameter int E_WIDTH = 512
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [WIDTH-1:0]     in_x_mont,
   input  logic [WIDTH-1:0]     in_r_mod_m,
   input  logic [E_WIDTH-1:0]   in_e,
   input  logic [WIDTH-1:0]     in_m,
   output logic [WIDTH-1:0]     result,
   output logic                 done,
   output logic                 busy,
   output logic                 mont_start,
   output logic [WIDTH-1:0]     mont_a,
   output logic [WIDTH-1:0]     mont_b,
   output logic [WIDTH-1:0]     mont_m,
   input  logic [WIDTH+1:0]     mont_result,
   input  logic                 mont_done
);

   localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_SQ        = 4'd1,
      ST_SQ_WAIT   = 4'd2,
      ST_MUL       = 4'd3,
      ST_MUL_WAIT  = 4'd4,
      ST_NEXT      = 4'd5,
      ST_CONV      = 4'd6,
      ST_CONV_WAIT = 4'd7,
      ST_DONE      = 4'd8
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [E_WIDTH-1:0]   e_q, e_d;
   logic [IW-1:0]        i_q, i_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 mont_start_q, mont_start_d;
   logic [WIDTH-1:0]     mont_b_q, mont_b_d;
   logic                 unused_s;

   // The multiplier guarantees a reduced output, so its two top bits are dropped.
   assign unused_s = ^mont_result[WIDTH+1:WIDTH];

   // Next-state, datapath register and registered-output computation.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      x_d      = x_q;
      m_d      = m_q;
      e_d      = e_q;
      i_d      = i_q;
      result_d = result_q;
      done_d   = done_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               x_d     = in_x_mont;
               m_d     = in_m;
               e_d     = in_e;
               a_d     = in_r_mod_m;
               i_d     = IW'(E_WIDTH - 1);
               done_d  = 1'b0;
               state_d = ST_SQ;
            end else begin
               state_d = state_q;
            end
         end
         ST_SQ:  state_d = ST_SQ_WAIT;
         ST_SQ_WAIT: begin
            if (mont_done) begin
               a_d     = mont_result[WIDTH-1:0];
               state_d = e_q[i_q] ? ST_MUL : ST_NEXT;
            end else begin
               state_d = ST_SQ_WAIT;
            end
         end
         ST_MUL: state_d = ST_MUL_WAIT;
         ST_MUL_WAIT: begin
            if (mont_done) begin
               a_d     = mont_result[WIDTH-1:0];
               state_d = ST_NEXT;
            end else begin
               state_d = ST_MUL_WAIT;
            end
         end
         ST_NEXT: begin
            if (i_q == {IW{1'b0}}) begin
               state_d = ST_CONV;
            end else begin
               i_d     = i_q - IW'(1);
               state_d = ST_SQ;
            end
         end
         ST_CONV: state_d = ST_CONV_WAIT;
         ST_CONV_WAIT: begin
            if (mont_done) begin
               result_d = mont_result[WIDTH-1:0];
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_CONV_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they leave flops cleanly.
      mont_start_d = (state_d == ST_SQ) || (state_d == ST_MUL) || (state_d == ST_CONV);
      busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);

      case (state_d)
         ST_SQ, ST_SQ_WAIT:     mont_b_d = a_d;
         ST_MUL, ST_MUL_WAIT:   mont_b_d = x_d;
         ST_CONV, ST_CONV_WAIT: mont_b_d = {{(WIDTH-1){1'b0}}, 1'b1};
         default:               mont_b_d = {WIDTH{1'b0}};
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         a_q          <= {WIDTH{1'b0}};
         x_q          <= {WIDTH{1'b0}};
         m_q          <= {WIDTH{1'b0}};
         e_q          <= {E_WIDTH{1'b0}};
         i_q          <= {IW{1'b0}};
         result_q     <= {WIDTH{1'b0}};
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         mont_start_q <= 1'b0;
         mont_b_q     <= {WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         x_q          <= x_d;
         m_q          <= m_d;
         e_q          <= e_d;
         i_q          <= i_d;
         result_q     <= result_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         mont_start_q <= mont_start_d;
         mont_b_q     <= mont_b_d;
      end
   end

   assign result     = result_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign mont_start = mont_start_q;
   assign mont_a     = a_q;
   assign mont_b     = mont_b_q;
   assign mont_m     = m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural Montgomery multiplier
// (R = 2^8, M = 13, done three cycles after start).
module tb_mod_exp_ctrl;

   localparam int WIDTH   = 8;
   localparam int E_WIDTH = 4;
   localparam int W       = 3;

   logic               clk;
   logic               resetn;
   logic               start;
   logic [WIDTH-1:0]   in_x_mont;
   logic [WIDTH-1:0]   in_r_mod_m;
   logic [E_WIDTH-1:0] in_e;
   logic [WIDTH-1:0]   in_m;
   logic [WIDTH-1:0]   result;
   logic               done;
   logic               busy;
   logic               mont_start;
   logic [WIDTH-1:0]   mont_a;
   logic [WIDTH-1:0]   mont_b;
   logic [WIDTH-1:0]   mont_m;
   logic [WIDTH+1:0]   mont_result;
   logic               mont_done;

   int checks;
   int errors;
   int pulses;
   int consec;
   logic prev_start;
   logic hold_done;
   int cnt;

   mod_exp_ctrl #(.WIDTH(WIDTH), .E_WIDTH(E_WIDTH)) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .in_x_mont(in_x_mont), .in_r_mod_m(in_r_mod_m), .in_e(in_e), .in_m(in_m),
      .result(result), .done(done), .busy(busy),
      .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
      .mont_result(mont_result), .mont_done(mont_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a*b*R^-1 mod m, with R = 2^WIDTH
   function automatic int mont_mul(input int a, input int b, input int m);
      int rinv;
      rinv = 0;
      for (int k = 1; k < m; k++) begin
         if (((k << WIDTH) % m) == 1) rinv = k;
      end
      return (a * b * rinv) % m;
   endfunction

   // Behavioural multiplier; done either pulses once or is held until the next start.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt         <= 0;
         mont_done   <= 1'b0;
         mont_result <= '0;
      end else if (mont_start) begin
         cnt         <= W - 1;
         mont_done   <= 1'b0;
         mont_result <= {2'b10, 8'(mont_mul(int'(mont_a), int'(mont_b), int'(mont_m)))};
      end else if (cnt != 0) begin
         cnt       <= cnt - 1;
         mont_done <= (cnt == 1);
      end else if (!hold_done) begin
         mont_done <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mont_start) begin
         pulses = pulses + 1;
         if (prev_start) consec = consec + 1;
      end
      prev_start = mont_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch a run and wait for done; poke > 0 re-asserts start in that cycle.
   task automatic run(input string tag, input logic [3:0] e, input int exp_res,
                      input int exp_pulses, input int exp_lat, input int poke);
      int cycles;
      int p0;
      p0     = pulses;
      in_e   = e;
      start  = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
         start = (cycles == poke) ? 1'b1 : 1'b0;
         if (cycles == 1) begin
            chk({tag, "_done_drop"}, 32'(done), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
         end
      end while (!done && cycles < 200);
      chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
      chk({tag, "_result"}, 32'(result), 32'(exp_res));
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pulses"}, 32'(pulses - p0), 32'(exp_pulses));
   endtask

   initial begin
      int guard;
      int p0;
      checks     = 0;
      errors     = 0;
      pulses     = 0;
      consec     = 0;
      prev_start = 1'b0;
      hold_done  = 1'b0;
      resetn     = 1'b0;
      start      = 1'b0;
      in_m       = 8'd13;
      in_r_mod_m = 8'd9;
      in_x_mont  = 8'd5;
      in_e       = 4'd0;

      #12;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mont_start", 32'(mont_start), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      run("e5", 4'b0101, 6, 7, 33, 0);
      run("e0", 4'b0000, 1, 5, 25, 0);
      run("e15", 4'b1111, 8, 9, 41, 0);
      run("e5_poke", 4'b0101, 6, 7, 33, 2);
      // Restart straight from DONE with a different exponent
      run("restart", 4'b1111, 8, 9, 41, 0);

      hold_done = 1'b1;
      run("stale", 4'b0101, 6, 7, 33, 0);
      hold_done = 1'b0;

      // Reset while waiting on the MUL operation (third pulse for e=0101)
      p0    = pulses;
      in_e  = 4'b0101;
      start = 1'b1;
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         start = 1'b0;
         guard++;
      end while ((pulses - p0) < 3 && guard < 200);
      chk("mul_reached", 32'(pulses - p0), 32'd3);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_mont_start", 32'(mont_start), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_mont_a", 32'(mont_a), 32'd0);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      run("post_rst", 4'b0101, 6, 7, 33, 0);

      chk("no_back_to_back", 32'(consec), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequencer that computes modular exponentiation, result = X^E mod M, by scheduling a single external `montgomery` multiplier through left-to-right square-and-multiply in the Montgomery domain. It sits between the RSA host interface and the multiplier: it latches operands, issues one Montgomery multiplication at a time over a start/done handshake, and finishes with a conversion out of the Montgomery domain.

## Interface
- WIDTH, 512, modulus/operand width; must match the multiplier.
- E_WIDTH, 512, exponent width; all E_WIDTH bits are scanned.
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin an exponentiation; sampled in IDLE and DONE only.
- in_x_mont  in  WIDTH  base in Montgomery form, X·R mod M, R = 2^WIDTH.
- in_r_mod_m  in  WIDTH  R mod M, the Montgomery "one".
- in_e  in  E_WIDTH  exponent.
- in_m  in  WIDTH  odd modulus.
- result  out  WIDTH  X^E mod M in the normal domain; valid while done=1.
- done  out  1  level; high in DONE until the next accepted start.
- busy  out  1  high in every state except IDLE and DONE.
- mont_start  out  1  one-cycle pulse launching a multiplication.
- mont_a, mont_b, mont_m  out  WIDTH each  multiplier operands.
- mont_result  in  WIDTH+2  multiplier output.
- mont_done  in  1  multiplier completion, level.

## Operation
- Registers: A (WIDTH), X, M, E (latched), bit index i (log2(E_WIDTH) bits), state.
- On accepted start: X<=in_x_mont, M<=in_m, E<=in_e, A<=in_r_mod_m, i<=E_WIDTH-1; go to SQ.
- States: IDLE, SQ, SQ_WAIT, MUL, MUL_WAIT, NEXT, CONV, CONV_WAIT, DONE.
- SQ: mont_start=1 for this cycle only; go to SQ_WAIT.
- SQ_WAIT: wait for mont_done=1; then A<=mont_result[WIDTH-1:0]; if E[i]=1 go to MUL, else go to NEXT.
- MUL: pulse mont_start, go to MUL_WAIT. MUL_WAIT: on mont_done, capture A as above, go to NEXT.
- NEXT: if i==0 go to CONV, else i<=i-1 and go to SQ.
- CONV: pulse mont_start, go to CONV_WAIT. CONV_WAIT: on mont_done, result<=mont_result[WIDTH-1:0], go to DONE.
- Operand mux, driven from registers only: mont_a=A in every state. mont_b=A in SQ/SQ_WAIT, X in MUL/MUL_WAIT, 1 (zero-extended) in CONV/CONV_WAIT, 0 otherwise. mont_m=M at all times.
- Operands are stable from the mont_start cycle until the cycle mont_done is sampled high.
- mont_result[WIDTH+1:WIDTH] is ignored; the multiplier guarantees its output is < M.
- start while busy is ignored. start in DONE restarts: done drops next cycle and the inputs are re-latched.
- E=0 yields exactly E_WIDTH squares of one, then CONV, giving result=1 (for M>1).

## Timing
- Reset values, asserted asynchronously: state=IDLE, done=0, busy=0, mont_start=0, result=0, A/X/M/E=0, i=0.
- Reset deasserted mid-run: the block returns to IDLE. The multiplier is reset by the same resetn.
- mont_done is sampled only in *_WAIT states. The first sample is the cycle after the mont_start pulse, so a stale done held over from the previous operation is never seen.
- Per multiplication: 1 issue cycle + W wait cycles, where W = number of cycles until mont_done is sampled high (W≥1).
- Total latency from the start cycle to done=1: (E_WIDTH + popcount(E) + 1)·(1+W) + E_WIDTH (NEXT cycles) + 1.
- Exactly E_WIDTH + popcount(E) + 1 mont_start pulses per run, never two in consecutive cycles.

## Test plan
Bench setup: WIDTH=8, E_WIDTH=4, and a behavioural Montgomery model with done asserted W=3 cycles after start. Test values: M=13, R mod M=9, x_mont=5 (X=2).
- e=4'b0101 -> result=6 (2^5 mod 13), done high. Exactly 7 mont_start pulses: SQ, SQ, MUL, SQ, SQ, MUL, CONV. Latency = 7·4+4+1 = 33 cycles.
- e=4'b0000 -> result=1, 5 pulses. e=4'b1111 -> result=8 (2^15 mod 13), 9 pulses.
- start pulsed again during SQ_WAIT -> ignored: no extra pulse, same result. start held in DONE -> done drops and a new run starts with the new operands.
- Stale done: model holds mont_done=1 continuously after completion -> the controller still waits for the fresh done of each operation and results match.
- resetn driven low in MUL_WAIT -> done/busy/mont_start/result go to 0 immediately. A subsequent start with e=5 gives result=6.
